// File: rtl/acc_drain_ctrl.sv
// Drains FIFO_DEPTH rows from the ACC FIFO bank in lockstep and writes each
// registered row to consecutive GLB addresses, honouring GLB backpressure.
module acc_drain_ctrl #(
  parameter int PE_SIZE    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  input  logic [DATA_WIDTH*PE_SIZE-1:0] acc_row_i,
  output logic [PE_SIZE-1:0]            rden_o,
  output logic                          glb_wren_o,
  input  logic                          glb_ready_i,
  output logic [ADDR_WIDTH-1:0]         glb_addr_o,
  output logic [DATA_WIDTH*PE_SIZE-1:0] glb_wdata_o,
  output logic                          busy_o,
  output logic                          done_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         row_cnt;
  logic [ADDR_WIDTH-1:0] base;
  logic                  pop;

  // A new row may enter the output register only when it is empty or being emptied.
  assign pop    = (state == DRAIN) && (!glb_wren_o || glb_ready_i);
  assign rden_o = {PE_SIZE{pop}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_cnt     <= '0;
      base        <= '0;
      glb_wren_o  <= 1'b0;
      glb_addr_o  <= '0;
      glb_wdata_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;

      if (pop) begin
        glb_wdata_o <= acc_row_i;
        glb_addr_o  <= base + ADDR_WIDTH'(row_cnt);
        glb_wren_o  <= 1'b1;
      end else if (glb_ready_i) begin
        glb_wren_o  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            base    <= base_addr_i;
            row_cnt <= '0;
            busy_o  <= 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop) begin
            row_cnt <= row_cnt + CW'(1);
            if (row_cnt == CW'(FIFO_DEPTH - 1)) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (glb_wren_o && glb_ready_i) begin
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Directed + randomized bench for acc_drain_ctrl, checked against a
// transaction-level model (row queue, pending-write slot, rows-left count).
module tb_acc_drain_ctrl;
  localparam int P = 4, D = 8, F = 4, A = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           ready = 1'b1;
  logic [A-1:0]   base = '0;
  logic [P*D-1:0] row = '0;
  logic [P-1:0]   rden;
  logic           wren, busy, done;
  logic [A-1:0]   addr;
  logic [P*D-1:0] wdata;

  acc_drain_ctrl #(.PE_SIZE(P), .DATA_WIDTH(D), .FIFO_DEPTH(F), .ADDR_WIDTH(A)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base),
    .acc_row_i(row), .rden_o(rden), .glb_wren_o(wren), .glb_ready_i(ready),
    .glb_addr_o(addr), .glb_wdata_o(wdata), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit armed = 0;
  logic [31:0] fifo[$];

  // model: busy flag, rows left to pop, pending GLB write, done pulse
  bit           m_busy, m_pend, m_done;
  int           m_left;
  logic [A-1:0] m_base, m_paddr;
  logic [31:0]  m_pdata;
  int           n_pop, n_wr;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive at negedge, check settled outputs, advance model over the edge
  task automatic cyc(bit s, bit r, bit rn = 1'b1);
    bit pop, hs, acc, nd;
    start = s; ready = r; rst_n = rn;
    row = (fifo.size() != 0) ? fifo[0] : '0;
    #1;
    pop = m_busy && (m_left > 0) && (!m_pend || r);
    if (armed) begin
      chk("rden", rden, {P{pop}});
      chk("wren", wren, m_pend);
      if (m_pend) begin
        chk("addr", addr, m_paddr);
        chk("data", wdata, m_pdata);
      end
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
    end
    if (rn) begin
      if (rden != '0) n_pop++;
      if (wren && r) n_wr++;
    end
    if (!rn) begin
      m_busy = 0; m_pend = 0; m_done = 0; m_left = 0;
      armed = 1;
    end else begin
      hs  = m_pend && r;
      acc = !m_busy && s;
      nd  = m_busy && (m_left == 0) && hs;
      if (pop) begin
        m_paddr = m_base + A'(F - m_left);
        m_pdata = (fifo.size() != 0) ? fifo.pop_front() : '0;
        m_pend  = 1;
        m_left--;
      end else if (r) begin
        m_pend = 0;
      end
      if (m_done) m_busy = 0;
      m_done = nd;
      if (acc) begin
        m_busy = 1; m_base = base; m_left = F;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill(int n);
    for (int i = 0; i < n; i++) fifo.push_back($urandom);
  endtask

  // start one drain and run to idle; rmode=1 gives random backpressure
  task automatic drain(logic [A-1:0] b, bit rmode);
    int i;
    n_pop = 0; n_wr = 0;
    base = b;
    cyc(1'b1, 1'b1);
    i = 0;
    while (m_busy && i < 200) begin
      cyc(1'b0, rmode ? ($urandom_range(0, 3) != 0) : 1'b1);
      i++;
    end
    chk("drain_timeout", m_busy, 0);
    chk("pop_count", n_pop, F);
    chk("write_count", n_wr, F);
  endtask

  initial begin
    int gap;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("rst_rden", rden, 0);
    chk("rst_wren", wren, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // basic drain with known rows
    fifo = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    drain(8'h10, 1'b0);

    // stall on the second write for three cycles
    fill(F);
    n_pop = 0; n_wr = 0;
    base = 8'h20;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 10 && m_busy; i++) cyc(1'b0, 1'b1);
    chk("stall_pops", n_pop, F);
    chk("stall_writes", n_wr, F);

    // address wrap
    fill(F);
    drain(8'hFE, 1'b0);

    // start while busy is ignored
    fill(F);
    base = 8'h30;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    base = 8'h80;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 20 && m_busy; i++) cyc(1'b0, 1'b1);
    fill(F);
    drain(8'h80, 1'b0);

    // reset after two pops
    fill(F);
    base = 8'h50;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("mid_rst_wren", wren, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_data", wdata, 0);
    chk("mid_rst_busy", busy, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    fifo.delete();
    fill(F);
    drain(8'h60, 1'b0);

    // back-to-back: start held high
    fill(2 * F);
    base = 8'h40;
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0 && !busy) gap++;
      cyc(1'b1, 1'b1);
    end
    for (int i = 0; i < 20 && m_busy; i++) cyc(1'b0, 1'b1);
    chk("b2b_gap", gap, 1);

    // randomized drains with random base and backpressure
    for (int k = 0; k < 8; k++) begin
      fill(F);
      drain(A'($urandom), 1'b1);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) cyc(1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
